// File: rtl/noc_local_nic.sv
// noc_local_nic: local NIC on a router L port; credit-based flit injection plus eject FIFO with credit return.
// Optional macro NIC_STATS_EN adds stat_tx_count/stat_rx_count event counters.
module noc_local_nic #(
    parameter int XCOORD   = 0,
    parameter int YCOORD   = 0,
    parameter int CREDITS  = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    input  logic [3:0]  tx_dest_x,
    input  logic [3:0]  tx_dest_y,
    input  logic [7:0]  tx_payload,
    output logic        tx_ready,
    output logic [15:0] inj_data,
    output logic        inj_enable,
    input  logic        inj_credit,
    input  logic [15:0] ej_data,
    input  logic        ej_enable,
    output logic        ej_credit,
    output logic        rx_valid,
    output logic [15:0] rx_data,
    input  logic        rx_ready,
    output logic        err_overflow,
    output logic        err_credit,
    output logic        err_misroute
`ifdef NIC_STATS_EN
   ,output logic [15:0] stat_tx_count,
    output logic [15:0] stat_rx_count
`endif
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int PW = $clog2(RX_DEPTH);
    localparam int NW = $clog2(RX_DEPTH + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);
    localparam logic [NW-1:0] NMAX = NW'(RX_DEPTH);
    localparam logic [3:0] XC = 4'(XCOORD);
    localparam logic [3:0] YC = 4'(YCOORD);

    logic [CW-1:0] credit_q, credit_d;
    logic [15:0]   inj_data_q, inj_data_d;
    logic          inj_enable_q, ej_credit_q;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, crd_q, crd_d, mis_q, mis_d;
    logic [15:0]   mem [RX_DEPTH];
    logic          accept, pop, full, wr;

    assign tx_ready = credit_q != '0;
    assign accept   = tx_valid & tx_ready;
    assign rx_valid = cnt_q != '0;
    assign rx_data  = mem[rd_q];
    assign pop      = rx_valid & rx_ready;
    assign full     = cnt_q == NMAX;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept a write.
    assign wr       = ej_enable & (~full | pop);

    always_comb begin
        credit_d   = credit_q;
        if (accept && !inj_credit)
            credit_d = credit_q - 1'b1;
        else if (!accept && inj_credit && credit_q != CMAX)
            credit_d = credit_q + 1'b1;
        inj_data_d = accept ? {tx_payload, tx_dest_x, tx_dest_y} : inj_data_q;
        rd_d       = rd_q + PW'(pop);
        wr_d       = wr_q + PW'(wr);
        cnt_d      = cnt_q + NW'(wr) - NW'(pop);
        crd_d      = crd_q | (~accept & inj_credit & (credit_q == CMAX));
        ovf_d      = ovf_q | (ej_enable & full & ~pop);
        mis_d      = mis_q | (wr & ((ej_data[7:4] != XC) | (ej_data[3:0] != YC)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_q     <= CMAX;
            inj_data_q   <= '0;
            inj_enable_q <= 1'b0;
            ej_credit_q  <= 1'b0;
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            crd_q        <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            inj_data_q   <= inj_data_d;
            inj_enable_q <= accept;
            ej_credit_q  <= pop;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            crd_q        <= crd_d;
            mis_q        <= mis_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_q] <= ej_data;
    end

    assign inj_data     = inj_data_q;
    assign inj_enable   = inj_enable_q;
    assign ej_credit    = ej_credit_q;
    assign err_overflow = ovf_q;
    assign err_credit   = crd_q;
    assign err_misroute = mis_q;

`ifdef NIC_STATS_EN
    logic [15:0] stx_q, srx_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stx_q <= '0;
            srx_q <= '0;
        end else begin
            stx_q <= stx_q + 16'(accept);
            srx_q <= srx_q + 16'(pop);
        end
    end
    assign stat_tx_count = stx_q;
    assign stat_rx_count = srx_q;
`endif
endmodule

// File: tb/tb_noc_local_nic.sv
// tb_noc_local_nic: directed bench with scoreboards for injected flits and ejected/popped flits.
module tb_noc_local_nic;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tx_valid = 1'b0;
    logic [3:0]  tx_dest_x = '0;
    logic [3:0]  tx_dest_y = '0;
    logic [7:0]  tx_payload = '0;
    logic        tx_ready;
    logic [15:0] inj_data;
    logic        inj_enable;
    logic        inj_credit = 1'b0;
    logic [15:0] ej_data = '0;
    logic        ej_enable = 1'b0;
    logic        ej_credit;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_ready = 1'b0;
    logic        err_overflow, err_credit, err_misroute;

    int checks = 0;
    int errors = 0;
    int inj_seen = 0;
    int inj_pushed = 0;
    logic [15:0] txq[$];
    logic [15:0] rxq[$];

    noc_local_nic dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y), .tx_payload(tx_payload),
        .tx_ready(tx_ready), .inj_data(inj_data), .inj_enable(inj_enable), .inj_credit(inj_credit),
        .ej_data(ej_data), .ej_enable(ej_enable), .ej_credit(ej_credit),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .err_overflow(err_overflow), .err_credit(err_credit), .err_misroute(err_misroute)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Record an injection the DUT should perform for the current tx_* inputs.
    task automatic push_tx();
        txq.push_back({tx_payload, tx_dest_x, tx_dest_y});
        inj_pushed++;
    endtask

    // Check head data before a pop edge, then the credit pulse one cycle later.
    task automatic pop_one(input string tag);
        logic [15:0] exp;
        exp = (rxq.size() != 0) ? rxq.pop_front() : 16'hxxxx;
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        chk({tag, "_data"}, {16'd0, rx_data}, {16'd0, exp});
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        chk({tag, "_credit"}, {31'd0, ej_credit}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst && inj_enable) begin
            inj_seen++;
            if (txq.size() == 0)
                chk("inj_unexpected", {16'd0, inj_data}, 32'hffffffff);
            else
                chk("inj_data", {16'd0, inj_data}, {16'd0, txq.pop_front()});
        end
    end

    initial begin
        int n;
        int base;
        #12;
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_inj_enable", {31'd0, inj_enable}, 32'd0);
        chk("rst_inj_data", {16'd0, inj_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_errs", {29'd0, err_overflow, err_credit, err_misroute}, 32'd0);
        chk("rst_ej_credit", {31'd0, ej_credit}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // Flit packing, then inj_data holds while idle.
        tx_valid = 1'b1; tx_dest_x = 4'd2; tx_dest_y = 4'd3; tx_payload = 8'hA5;
        push_tx();
        cyc();
        tx_valid = 1'b0;
        chk("pack_enable", {31'd0, inj_enable}, 32'd1);
        chk("pack_data", {16'd0, inj_data}, 32'h0000A523);
        cyc();
        chk("hold_enable", {31'd0, inj_enable}, 32'd0);
        chk("hold_data", {16'd0, inj_data}, 32'h0000A523);
        inj_credit = 1'b1;
        cyc();
        inj_credit = 1'b0;

        // Credit exhaustion with tx_valid held high.
        base = inj_seen;
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_payload = 8'h10 + 8'(i);
            #1;
            chk($sformatf("exh_ready%0d", i), {31'd0, tx_ready}, {31'd0, i < 4});
            if (tx_ready) push_tx();
            cyc();
        end
        tx_valid = 1'b0;
        chk("exh_pulses", inj_seen - base, 32'd4);
        inj_credit = 1'b1;
        cyc();
        inj_credit = 1'b0;
        chk("exh_refill_ready", {31'd0, tx_ready}, 32'd1);
        tx_valid = 1'b1; tx_payload = 8'h5A; tx_dest_x = 4'd7; tx_dest_y = 4'd1;
        push_tx();
        cyc();
        tx_valid = 1'b0;
        chk("exh_empty_again", {31'd0, tx_ready}, 32'd0);
        inj_credit = 1'b1;
        repeat (4) cyc();
        inj_credit = 1'b0;

        // Accept + inj_credit in one cycle leaves the count unchanged (3 here).
        tx_valid = 1'b1; tx_payload = 8'h21;
        push_tx();
        cyc();
        inj_credit = 1'b1; tx_payload = 8'h22;
        push_tx();
        cyc();
        inj_credit = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tx_payload = 8'h30 + 8'(i);
            #1;
            if (tx_ready) begin
                push_tx();
                n++;
            end
            cyc();
        end
        tx_valid = 1'b0;
        chk("simul_credit_count", n, 32'd3);
        inj_credit = 1'b1;
        repeat (4) cyc();
        inj_credit = 1'b0;
        chk("no_err_credit_yet", {31'd0, err_credit}, 32'd0);
        inj_credit = 1'b1;
        cyc();
        inj_credit = 1'b0;
        chk("err_credit", {31'd0, err_credit}, 32'd1);
        chk("err_credit_ready", {31'd0, tx_ready}, 32'd1);

        // Eject fill, overflow drop, full write+pop, drain.
        ej_enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ej_data = 16'(i) << 8;
            rxq.push_back(ej_data);
            cyc();
        end
        ej_enable = 1'b0;
        chk("fill_valid", {31'd0, rx_valid}, 32'd1);
        chk("fill_head", {16'd0, rx_data}, 32'h0100);
        chk("no_overflow_yet", {31'd0, err_overflow}, 32'd0);
        ej_enable = 1'b1; ej_data = 16'h0500;
        cyc();
        ej_enable = 1'b0;
        chk("err_overflow", {31'd0, err_overflow}, 32'd1);
        chk("drop_head", {16'd0, rx_data}, 32'h0100);
        ej_enable = 1'b1; ej_data = 16'h0600;
        chk("full_wp_data", {16'd0, rx_data}, {16'd0, rxq.pop_front()});
        rxq.push_back(16'h0600);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0; ej_enable = 1'b0;
        chk("full_wp_credit", {31'd0, ej_credit}, 32'd1);
        for (int i = 0; i < 4; i++) pop_one($sformatf("drain%0d", i));
        cyc();
        chk("drain_credit_end", {31'd0, ej_credit}, 32'd0);
        chk("drain_empty", {31'd0, rx_valid}, 32'd0);

        // Write with pop on empty: write lands, pop ignored.
        ej_enable = 1'b1; ej_data = 16'h0700; rx_ready = 1'b1;
        rxq.push_back(16'h0700);
        cyc();
        ej_enable = 1'b0; rx_ready = 1'b0;
        chk("empty_wp_credit", {31'd0, ej_credit}, 32'd0);
        pop_one("empty_wp");

        // Misrouted flit is flagged but delivered.
        chk("no_misroute_yet", {31'd0, err_misroute}, 32'd0);
        ej_enable = 1'b1; ej_data = 16'h0012;
        rxq.push_back(16'h0012);
        cyc();
        ej_enable = 1'b0;
        chk("err_misroute", {31'd0, err_misroute}, 32'd1);
        pop_one("misroute");

        // Reset mid-traffic: FIFO holds 2, credit 1.
        ej_enable = 1'b1;
        ej_data = 16'h0A00; cyc();
        ej_data = 16'h0B00; cyc();
        ej_enable = 1'b0;
        tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_payload = 8'hC0 + 8'(i);
            push_tx();
            cyc();
        end
        tx_valid = 1'b0;
        cyc();
        chk("pre_rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("inj_all_seen", inj_seen, inj_pushed);
        #2 rst = 1'b0;
        #1;
        chk("async_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("async_errs", {29'd0, err_overflow, err_credit, err_misroute}, 32'd0);
        chk("async_inj_enable", {31'd0, inj_enable}, 32'd0);
        rxq.delete();
        #3 rst = 1'b1;
        n = 0;
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_payload = 8'hE0 + 8'(i);
            #1;
            if (tx_ready) begin
                push_tx();
                n++;
            end
            cyc();
        end
        tx_valid = 1'b0;
        cyc();
        chk("post_rst_credits", n, 32'd4);
        chk("post_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("txq_drained", txq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
